// File: rtl/irq_controller.sv
// Machine-level external interrupt controller: fixed-priority arbitration of
// level requests against mie, one-cycle trap pulse, registered cause, mret ack.
module irq_controller #(
  parameter int          IRQ_NUM    = 16,
  parameter logic [31:0] CAUSE_BASE = 32'h8000_0010
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [IRQ_NUM-1:0] irq_req_i,
  input  logic [31:0]        mie_i,
  input  logic               stall_i,
  input  logic               mret_i,
  output logic               irq_o,
  output logic [31:0]        irq_cause_o,
  output logic [IRQ_NUM-1:0] irq_ret_o,
  output logic               busy_o
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_TRAP    = 2'd1;
  localparam logic [1:0] ST_SERVICE = 2'd2;
  localparam logic [1:0] ST_RETURN  = 2'd3;

  logic [1:0]         state;
  logic [1:0]         state_next;
  logic [3:0]         idx_q;
  logic [3:0]         idx_next;
  logic [IRQ_NUM-1:0] cand;
  logic               any_cand;
  logic [3:0]         win_idx;
  logic               capture;
  logic [31:0]        cause_next;
  logic [IRQ_NUM-1:0] ret_next;
  logic               unused_mie;

  // Lowest set bit wins: line 0 has the highest priority.
  function automatic logic [3:0] lowest_set(input logic [IRQ_NUM-1:0] v);
    logic [3:0] r;
    r = 4'd0;
    for (int k = IRQ_NUM - 1; k >= 0; k--) begin
      if (v[k]) r = 4'(k);
    end
    return r;
  endfunction

  assign cand       = irq_req_i & mie_i[16 +: IRQ_NUM];
  assign any_cand   = |cand;
  assign win_idx    = lowest_set(cand);
  assign cause_next = CAUSE_BASE + {28'd0, win_idx};
  assign unused_mie = ^mie_i;

  always_comb begin
    state_next = state;
    idx_next   = idx_q;
    capture    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (any_cand && !stall_i) begin
          capture    = 1'b1;
          idx_next   = win_idx;
          state_next = ST_TRAP;
        end
      end
      ST_TRAP:    state_next = ST_SERVICE;
      ST_SERVICE: if (mret_i) state_next = ST_RETURN;
      ST_RETURN:  state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // Acknowledge targets the captured line even if its request has since dropped.
  always_comb begin
    ret_next = '0;
    for (int k = 0; k < IRQ_NUM; k++) begin
      ret_next[k] = (state_next == ST_RETURN) && (idx_q == 4'(k));
    end
  end

  // Outputs are decoded from the next state so every output comes from a flop.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state       <= ST_IDLE;
      idx_q       <= 4'd0;
      irq_o       <= 1'b0;
      irq_cause_o <= 32'h0;
      irq_ret_o   <= '0;
      busy_o      <= 1'b0;
    end else begin
      state     <= state_next;
      idx_q     <= idx_next;
      irq_o     <= (state_next == ST_TRAP);
      busy_o    <= (state_next == ST_TRAP) || (state_next == ST_SERVICE);
      irq_ret_o <= ret_next;
      if (capture) irq_cause_o <= cause_next;
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
// Directed plus randomized bench for irq_controller, checked against an
// ownership-based reference model of the interrupt lifecycle.
module tb_irq_controller;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [15:0] irq_req_i;
  logic [31:0] mie_i;
  logic        stall_i;
  logic        mret_i;
  logic        irq_o;
  logic [31:0] irq_cause_o;
  logic [15:0] irq_ret_o;
  logic        busy_o;

  int total = 0;
  int bad   = 0;

  // Reference model: who owns the controller and what is expected this cycle.
  bit          m_owned;
  bit          m_fresh;
  bit          m_acking;
  bit          m_trap;
  logic [15:0] m_ret;
  logic [31:0] m_cause;
  int          m_line;

  irq_controller #(
    .IRQ_NUM   (16),
    .CAUSE_BASE(32'h8000_0010)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .irq_req_i  (irq_req_i),
    .mie_i      (mie_i),
    .stall_i    (stall_i),
    .mret_i     (mret_i),
    .irq_o      (irq_o),
    .irq_cause_o(irq_cause_o),
    .irq_ret_o  (irq_ret_o),
    .busy_o     (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owned  = 1'b0;
    m_fresh  = 1'b0;
    m_acking = 1'b0;
    m_trap   = 1'b0;
    m_ret    = '0;
    m_cause  = 32'h0;
    m_line   = 0;
  endtask

  task automatic model_edge();
    logic [15:0] c;
    logic [15:0] low;
    m_trap = 1'b0;
    m_ret  = '0;
    if (m_acking) begin
      m_acking = 1'b0;
    end else if (!m_owned) begin
      c = irq_req_i & mie_i[31:16];
      if (c != 16'h0 && !stall_i) begin
        low = c & (~c + 16'd1);
        for (int k = 0; k < 16; k++) if (low == 16'(1 << k)) m_line = k;
        m_cause = 32'h8000_0010 + 32'(m_line);
        m_owned = 1'b1;
        m_fresh = 1'b1;
        m_trap  = 1'b1;
      end
    end else if (m_fresh) begin
      m_fresh = 1'b0;
    end else if (mret_i) begin
      m_owned  = 1'b0;
      m_acking = 1'b1;
      m_ret    = 16'(1 << m_line);
    end
  endtask

  task automatic check_all();
    check("irq",   32'(irq_o),     32'(m_trap));
    check("busy",  32'(busy_o),    32'(m_owned));
    check("ret",   32'(irq_ret_o), 32'(m_ret));
    check("cause", irq_cause_o,    m_cause);
  endtask

  task automatic step(input logic [15:0] r, input logic [31:0] m, input logic s, input logic t);
    irq_req_i = r;
    mie_i     = m;
    stall_i   = s;
    mret_i    = t;
    @(posedge clk_i);
    if (rst_i) model_edge(); else model_reset();
    #1;
    check_all();
  endtask

  task automatic async_reset();
    #2 rst_i = 1'b0;
    model_reset();
    #1;
    check_all();
    @(negedge clk_i);
    rst_i = 1'b1;
  endtask

  initial begin
    model_reset();
    rst_i = 1'b0;

    // Reset holds everything quiet despite enabled requests.
    for (int i = 0; i < 3; i++) begin
      step(16'hFFFF, 32'hFFFF_0000, 1'b0, 1'b0);
      check("rst_irq", 32'(irq_o), 32'h0);
    end
    @(negedge clk_i);
    rst_i = 1'b1;
    step(16'hFFFF, 32'hFFFF_0000, 1'b0, 1'b0);
    check("rel_irq", 32'(irq_o), 32'h1);
    check("rel_cause", irq_cause_o, 32'h8000_0010);
    step(16'h0000, 32'hFFFF_0000, 1'b0, 1'b0);
    step(16'h0000, 32'hFFFF_0000, 1'b0, 1'b1);
    check("rel_ret", 32'(irq_ret_o), 32'h0001);
    step(16'h0000, 32'hFFFF_0000, 1'b0, 1'b0);

    // Single entry and return on line 5.
    step(16'h0020, 32'h0020_0000, 1'b0, 1'b0);
    check("one_cause", irq_cause_o, 32'h8000_0015);
    check("one_busy", 32'(busy_o), 32'h1);
    step(16'h0020, 32'h0020_0000, 1'b0, 1'b0);
    check("one_pulse", 32'(irq_o), 32'h0);
    step(16'h0000, 32'h0020_0000, 1'b0, 1'b1);
    check("one_ret", 32'(irq_ret_o), 32'h0020);
    check("one_busy0", 32'(busy_o), 32'h0);
    step(16'h0000, 32'h0020_0000, 1'b0, 1'b0);
    check("one_ret0", 32'(irq_ret_o), 32'h0);

    // Priority and masking: line 2 then line 15; line 1 is masked.
    step(16'h8006, 32'h8004_0000, 1'b0, 1'b0);
    check("pri_cause2", irq_cause_o, 32'h8000_0012);
    step(16'h8006, 32'h8004_0000, 1'b0, 1'b0);
    step(16'h8006, 32'h8004_0000, 1'b0, 1'b1);
    check("pri_ret2", 32'(irq_ret_o), 32'h0004);
    step(16'h8002, 32'h8004_0000, 1'b0, 1'b0);
    step(16'h8002, 32'h8004_0000, 1'b0, 1'b0);
    check("pri_cause15", irq_cause_o, 32'h8000_001F);
    step(16'h8002, 32'h8004_0000, 1'b0, 1'b0);
    step(16'h0002, 32'h8004_0000, 1'b0, 1'b1);
    check("pri_ret15", 32'(irq_ret_o), 32'h8000);
    step(16'h0002, 32'h8004_0000, 1'b0, 1'b0);
    step(16'h0002, 32'h8004_0000, 1'b0, 1'b0);
    check("pri_mask1", 32'(irq_o), 32'h0);

    // Stall defers entry.
    for (int i = 0; i < 3; i++) begin
      step(16'h0008, 32'hFFFF_0000, 1'b1, 1'b0);
      check("stall_irq", 32'(irq_o), 32'h0);
    end
    step(16'h0008, 32'hFFFF_0000, 1'b0, 1'b0);
    check("stall_go", 32'(irq_o), 32'h1);
    check("stall_cause", irq_cause_o, 32'h8000_0013);
    step(16'h0000, 32'hFFFF_0000, 1'b0, 1'b0);
    step(16'h0000, 32'hFFFF_0000, 1'b0, 1'b1);
    step(16'h0000, 32'hFFFF_0000, 1'b0, 1'b0);

    // No nesting; request drop still acknowledged; back-to-back at M+3.
    step(16'h0010, 32'hFFFF_0000, 1'b0, 1'b0);
    step(16'h0011, 32'hFFFF_0000, 1'b0, 1'b0);
    step(16'h0011, 32'hFFFF_0000, 1'b0, 1'b0);
    check("nest_irq", 32'(irq_o), 32'h0);
    step(16'h0001, 32'hFFFF_0000, 1'b0, 1'b1);
    check("drop_ret", 32'(irq_ret_o), 32'h0010);
    step(16'h0001, 32'hFFFF_0000, 1'b0, 1'b0);
    check("b2b_gap", 32'(irq_o), 32'h0);
    step(16'h0001, 32'hFFFF_0000, 1'b0, 1'b0);
    check("b2b_irq", 32'(irq_o), 32'h1);
    check("b2b_cause", irq_cause_o, 32'h8000_0010);
    step(16'h0000, 32'hFFFF_0000, 1'b0, 1'b0);
    step(16'h0000, 32'hFFFF_0000, 1'b0, 1'b1);
    step(16'h0000, 32'hFFFF_0000, 1'b0, 1'b0);

    // Asynchronous reset in the middle of service.
    step(16'h0004, 32'hFFFF_0000, 1'b0, 1'b0);
    step(16'h0000, 32'hFFFF_0000, 1'b0, 1'b0);
    async_reset();
    check("midrst_busy", 32'(busy_o), 32'h0);
    check("midrst_cause", irq_cause_o, 32'h0);
    step(16'h0000, 32'hFFFF_0000, 1'b0, 1'b1);
    step(16'h0000, 32'hFFFF_0000, 1'b0, 1'b1);
    check("midrst_ret", 32'(irq_ret_o), 32'h0);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      logic [15:0] r;
      logic [31:0] m;
      r = 16'($urandom) & 16'($urandom);
      if ($urandom_range(0, 4) == 0) r = 16'h0;
      m = $urandom;
      step(r, m, ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0));
      if ($urandom_range(0, 99) == 0) async_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/irq_controller.md
# irq_controller

Machine-level external interrupt controller for the single-cycle RISC-V core, placed directly upstream of the CSR controller. It arbitrates 16 level-sensitive peripheral request lines against the enable mask held in `mie`. It produces the one-cycle `trap` pulse and the `mcause` value that the CSR controller latches into `mepc`/`mcause`. On `mret` it returns a one-hot acknowledge to the serviced peripheral. There is no nesting: one interrupt is in service at a time.

## Interface
Parameters:
- `IRQ_NUM`, 16: number of request lines. Fixed range 1..16.
- `CAUSE_BASE`, 32'h8000_0010: `mcause` value for line 0. Line k reports `CAUSE_BASE + k`.

Ports:
- `clk_i`  in  1  core clock
- `rst_i`  in  1  reset; asynchronous, active-low
- `irq_req_i`  in  IRQ_NUM  level requests; bit k = line k
- `mie_i`  in  32  `mie` CSR contents; line k is enabled by bit `16+k`
- `stall_i`  in  1  core stalled (LSU busy); interrupt entry is deferred while high
- `mret_i`  in  1  decoder flags an `mret` retiring this cycle
- `irq_o`  out  1  trap pulse to the CSR controller (`trap_i`) and the PC mux
- `irq_cause_o`  out  32  `mcause` value (to `mcause_i`)
- `irq_ret_o`  out  IRQ_NUM  one-hot acknowledge pulse to the serviced peripheral
- `busy_o`  out  1  interrupt in service (TRAP or SERVICE state)

## Operation
- Candidate vector: `irq_req_i & mie_i[16 +: IRQ_NUM]`. The lowest-index set bit wins (fixed priority, line 0 highest).
- FSM states:
  - IDLE
    - If any candidate is set and `stall_i`=0: capture the winning index into `idx_q`, load `irq_cause_o <= CAUSE_BASE + idx`, go to TRAP.
    - Otherwise stay in IDLE. `mret_i` is ignored.
  - TRAP
    - `irq_o`=1 for exactly this one cycle.
    - Always go to SERVICE next cycle. `stall_i` and `mret_i` are ignored.
  - SERVICE
    - Wait for `mret_i`=1, then go to RETURN.
    - Requests and `mie_i` changes are ignored here: no nesting and no preemption.
  - RETURN
    - `irq_ret_o = 1 << idx_q` for exactly this one cycle.
    - Always go to IDLE next cycle.
- `busy_o` = 1 in TRAP and SERVICE.
- `irq_cause_o` is registered. It holds its value from TRAP until the next IDLE→TRAP capture, so the CSR controller and software see a stable cause.
- Deassertion of a request after capture does not cancel service. The acknowledge still fires on `mret`.
- Lines with index ≥ `IRQ_NUM` and `mie_i` bits outside `[16 +: IRQ_NUM]` have no effect.
- Reset (asynchronous, any state, including mid-SERVICE):
  - state = IDLE, `idx_q` = 0
  - `irq_o` = 0, `irq_cause_o` = 32'h0, `irq_ret_o` = 0, `busy_o` = 0
  - The pending `mret` is forgotten; no acknowledge is issued.

## Timing
- Entry latency:
  - A candidate is sampled in IDLE at rising edge N with `stall_i`=0.
  - `irq_o`=1 and the valid `irq_cause_o` appear during cycle N+1.
  - The CSR controller writes `mepc`/`mcause` at edge N+2.
- Stall handling: when `stall_i`=1 at edge N, entry is deferred. Sampling repeats at every later edge. Arbitration uses the candidate vector at the accepting edge, not the first sighting.
- Return latency:
  - `mret_i` is sampled in SERVICE at edge M.
  - `irq_ret_o` is high during cycle M+1 only.
  - IDLE is reached from edge M+2.
- Minimum back-to-back spacing: with a request still pending, the next `irq_o` occurs in cycle M+3.
- Simultaneous events:
  - `mret_i` in TRAP is ignored (it must not occur architecturally).
  - If the request and mask change in the same cycle as IDLE sampling, the values present at the edge are used.
- All outputs are driven directly from flops; there are no combinational paths from inputs to outputs.

## Test plan
- Reset behaviour:
  - Stimulus: hold `rst_i`=0 with `irq_req_i`=16'hFFFF and `mie_i`=32'hFFFF_0000.
  - Required: all outputs 0 and no `irq_o`.
  - Then release reset: `irq_o` pulses in the 2nd cycle after release with `irq_cause_o`=32'h8000_0010.
- Single interrupt entry and return:
  - Stimulus: `irq_req_i`=16'h0020, `mie_i`=32'h0020_0000.
  - Required: `irq_o` 1-cycle pulse, `irq_cause_o`=32'h8000_0015, `busy_o`=1.
  - Then `mret_i` for 1 cycle: `irq_ret_o`=16'h0020 for exactly 1 cycle, `busy_o`=0.
- Priority and mask:
  - Stimulus: `irq_req_i`=16'h8006, `mie_i`=32'h8004_0000.
  - Required: line 2 is served first (cause 32'h8000_0012, ack 16'h0004), then line 15 (cause 32'h8000_001F, ack 16'h8000). Line 1 is never served.
- Stall deferral:
  - Stimulus: a request arrives with `stall_i`=1 held for 3 cycles.
  - Required: `irq_o` stays 0 throughout, then pulses in the cycle after the first edge with `stall_i`=0.
- No nesting, and request drop:
  - Stimulus: in SERVICE for line 4, raise line 0; then drop line 4 and assert `mret_i`.
  - Required: no second `irq_o` during SERVICE; `irq_ret_o`=16'h0010; line 0 then enters at M+3 with cause 32'h8000_0010.
- Reset mid-service:
  - Stimulus: assert `rst_i`=0 asynchronously while in SERVICE.
  - Required: outputs drop to 0 immediately, without waiting for a clock edge. A later `mret_i` in IDLE produces no `irq_ret_o`.
